// File: rtl/vc_dest_router_pkg.sv
// Shared definitions for the VC destination router.
//  - router_state_t : FSM state encoding (IDLE/RUN/HOLD)
//  - vc_sel_t       : which virtual channel a popped word came from
package vc_dest_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } router_state_t;

    typedef enum logic {
        SEL_VC0 = 1'b0,
        SEL_VC1 = 1'b1
    } vc_sel_t;

endpackage

// File: rtl/vc_priority_arb.sv
// Pop arbiter for the two virtual channels: VC0 has strict priority,
// but after STARVE_LIMIT consecutive VC0 grants with VC1 waiting, VC1
// is forced one grant.
// Ports:
//  clk, reset_L          clock, synchronous active-low reset
//  pop_en                pops are allowed this cycle (RUN, no pause, out of reset)
//  vc0_empty, vc1_empty  VC FIFO empty flags
//  pop_vc0, pop_vc1      combinational pop strobes (at most one high)
//  grant_sel             source of this cycle's grant (valid when a pop is high)
module vc_priority_arb
    import vc_dest_router_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic    clk,
    input  logic    reset_L,
    input  logic    pop_en,
    input  logic    vc0_empty,
    input  logic    vc1_empty,
    output logic    pop_vc0,
    output logic    pop_vc1,
    output vc_sel_t grant_sel
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_cnt;
    logic                force_vc1;

    assign force_vc1 = (starve_cnt == STARVE_W'(STARVE_LIMIT)) && !vc1_empty;

    // Empty flags are sampled in the same cycle as the decision, so an
    // empty VC can never be popped.
    always_comb begin
        pop_vc0   = 1'b0;
        pop_vc1   = 1'b0;
        grant_sel = SEL_VC0;
        if (pop_en) begin
            pop_vc0 = !vc0_empty && !force_vc1;
            pop_vc1 = !vc1_empty && (vc0_empty || force_vc1);
        end
        if (pop_vc1) begin
            grant_sel = SEL_VC1;
        end
    end

    // Counts VC0 grants taken while VC1 is waiting; the clear has priority,
    // and a forced VC1 grant suppresses VC0, so the count stops at the limit.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            starve_cnt <= '0;
        end else if (vc1_empty || pop_vc1) begin
            starve_cnt <= '0;
        end else if (pop_vc0) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

endmodule

// File: rtl/vc_dest_router.sv
// Drains VC0/VC1 and pushes each word into fifo_d0 or fifo_d1 according
// to word[DEST_BIT]. Pop-to-push latency is 2 cycles, one word per cycle.
// Ports:
//  clk, reset_L          clock, synchronous active-low reset
//  vc0_empty, vc1_empty  VC FIFO empty flags
//  vc0_data, vc1_data    VC FIFO read data (valid the cycle after a pop)
//  pause_d0, pause_d1    backpressure from the destination FIFOs
//  pop_vc0, pop_vc1      pop strobes (combinational)
//  push_d0, push_d1      push strobes (registered)
//  data_d0, data_d1      pushed words (registered, hold when not pushing)
//  cnt_d0, cnt_d1        words pushed per destination since reset (wrapping)
//  idle                  nothing queued, nothing in flight, FSM in IDLE
module vc_dest_router
    import vc_dest_router_pkg::*;
#(
    parameter int DATA_SIZE    = 8,
    parameter int DEST_BIT     = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 vc0_empty,
    input  logic                 vc1_empty,
    input  logic [DATA_SIZE-1:0] vc0_data,
    input  logic [DATA_SIZE-1:0] vc1_data,
    input  logic                 pause_d0,
    input  logic                 pause_d1,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic                 push_d0,
    output logic                 push_d1,
    output logic [DATA_SIZE-1:0] data_d0,
    output logic [DATA_SIZE-1:0] data_d1,
    output logic [CNT_WIDTH-1:0] cnt_d0,
    output logic [CNT_WIDTH-1:0] cnt_d1,
    output logic                 idle
);

    router_state_t        state_q;
    router_state_t        state_d;
    vc_sel_t              grant_sel;
    vc_sel_t              src_sel;
    logic                 valid1;
    logic                 pause_any;
    logic                 work_pending;
    logic                 pop_en;
    logic [DATA_SIZE-1:0] word;
    logic                 word_dest;

    assign pause_any    = pause_d0 | pause_d1;
    assign work_pending = !vc0_empty || !vc1_empty;

    // The destination is unknown until the word is read, so either pause
    // blocks every pop.
    assign pop_en = reset_L && (state_q == ST_RUN) && !pause_any;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (work_pending) begin
                    state_d = pause_any ? ST_HOLD : ST_RUN;
                end
            end
            ST_RUN: begin
                if (pause_any) begin
                    state_d = ST_HOLD;
                end else if (!work_pending) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!pause_any) begin
                    state_d = work_pending ? ST_RUN : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    vc_priority_arb #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk       (clk),
        .reset_L   (reset_L),
        .pop_en    (pop_en),
        .vc0_empty (vc0_empty),
        .vc1_empty (vc1_empty),
        .pop_vc0   (pop_vc0),
        .pop_vc1   (pop_vc1),
        .grant_sel (grant_sel)
    );

    // Remember which VC was popped; its read data appears next cycle.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            valid1  <= 1'b0;
            src_sel <= SEL_VC0;
        end else begin
            valid1  <= pop_vc0 | pop_vc1;
            src_sel <= grant_sel;
        end
    end

    assign word      = (src_sel == SEL_VC1) ? vc1_data : vc0_data;
    assign word_dest = word[DEST_BIT];

    // Capture the read word straight into the selected destination register;
    // the counter steps on the same edge that raises the push.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            push_d0 <= 1'b0;
            push_d1 <= 1'b0;
            data_d0 <= '0;
            data_d1 <= '0;
            cnt_d0  <= '0;
            cnt_d1  <= '0;
        end else begin
            push_d0 <= valid1 && !word_dest;
            push_d1 <= valid1 && word_dest;
            if (valid1 && !word_dest) begin
                data_d0 <= word;
                cnt_d0  <= cnt_d0 + CNT_WIDTH'(1);
            end
            if (valid1 && word_dest) begin
                data_d1 <= word;
                cnt_d1  <= cnt_d1 + CNT_WIDTH'(1);
            end
        end
    end

    assign idle = (state_q == ST_IDLE) && !work_pending && !valid1;

endmodule

// File: tb/tb_vc_dest_router.sv
// Self-checking bench for vc_dest_router. The VC FIFOs are emulated with
// queues; a behavioural model predicts pops, pushes, data, counters and
// idle every cycle, and directed scenarios pin the model with literals.
module tb_vc_dest_router;

    localparam int DATA_SIZE    = 8;
    localparam int DEST_BIT     = 4;
    localparam int STARVE_LIMIT = 4;
    localparam int CNT_WIDTH    = 8;
    localparam int CNT_MOD      = 1 << CNT_WIDTH;

    logic                 clk       = 1'b0;
    logic                 reset_L   = 1'b0;
    logic                 vc0_empty = 1'b1;
    logic                 vc1_empty = 1'b1;
    logic [DATA_SIZE-1:0] vc0_data  = '0;
    logic [DATA_SIZE-1:0] vc1_data  = '0;
    logic                 pause_d0  = 1'b0;
    logic                 pause_d1  = 1'b0;
    logic                 pop_vc0;
    logic                 pop_vc1;
    logic                 push_d0;
    logic                 push_d1;
    logic [DATA_SIZE-1:0] data_d0;
    logic [DATA_SIZE-1:0] data_d1;
    logic [CNT_WIDTH-1:0] cnt_d0;
    logic [CNT_WIDTH-1:0] cnt_d1;
    logic                 idle;

    always #5 clk = ~clk;

    vc_dest_router #(
        .DATA_SIZE    (DATA_SIZE),
        .DEST_BIT     (DEST_BIT),
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .vc0_empty (vc0_empty),
        .vc1_empty (vc1_empty),
        .vc0_data  (vc0_data),
        .vc1_data  (vc1_data),
        .pause_d0  (pause_d0),
        .pause_d1  (pause_d1),
        .pop_vc0   (pop_vc0),
        .pop_vc1   (pop_vc1),
        .push_d0   (push_d0),
        .push_d1   (push_d1),
        .data_d0   (data_d0),
        .data_d1   (data_d1),
        .cnt_d0    (cnt_d0),
        .cnt_d1    (cnt_d1),
        .idle      (idle)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Emulated VC FIFO contents.
    logic [DATA_SIZE-1:0] q0[$];
    logic [DATA_SIZE-1:0] q1[$];

    // Pops seen by the compare process, consumed by the FIFO emulation.
    logic seen_pop0 = 1'b0;
    logic seen_pop1 = 1'b0;

    // Observation logs for the directed scenarios.
    string grant_log = "";
    int    push_total = 0;
    int    push_d0_total = 0;
    int    ev_dest[$];
    int    ev_data[$];
    int    ev_cycle[$];

    // Reference model: RUN in a cycle means the previous cycle was out of
    // reset, unpaused and had work; idle-state tracking follows the same idea.
    logic                 m_run    = 1'b0;
    logic                 m_idle   = 1'b1;
    int                   m_streak = 0;
    logic                 s1_v = 1'b0;
    logic                 s2_v = 1'b0;
    logic [DATA_SIZE-1:0] s1_w = '0;
    logic [DATA_SIZE-1:0] s2_w = '0;
    logic [DATA_SIZE-1:0] m_data0 = '0;
    logic [DATA_SIZE-1:0] m_data1 = '0;
    int                   m_cnt0 = 0;
    int                   m_cnt1 = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    // Compare process: predicts and checks every cycle at the falling edge.
    always @(negedge clk) begin
        logic any_ne;
        logic pause_any;
        logic force1;
        logic exp_pop0;
        logic exp_pop1;
        cycle++;
        any_ne    = !vc0_empty || !vc1_empty;
        pause_any = pause_d0 || pause_d1;
        exp_pop0  = 1'b0;
        exp_pop1  = 1'b0;
        if (reset_L && m_run && !pause_any) begin
            force1 = (m_streak >= STARVE_LIMIT) && !vc1_empty;
            if (!vc0_empty && !force1) exp_pop0 = 1'b1;
            else if (!vc1_empty)       exp_pop1 = 1'b1;
        end

        checkOutput("pop_vc0", 32'(pop_vc0), 32'(exp_pop0));
        checkOutput("pop_vc1", 32'(pop_vc1), 32'(exp_pop1));
        checkOutput("push_d0", 32'(push_d0), 32'(s2_v && !s2_w[DEST_BIT]));
        checkOutput("push_d1", 32'(push_d1), 32'(s2_v && s2_w[DEST_BIT]));
        checkOutput("data_d0", 32'(data_d0), 32'(m_data0));
        checkOutput("data_d1", 32'(data_d1), 32'(m_data1));
        checkOutput("cnt_d0", 32'(cnt_d0), 32'(m_cnt0));
        checkOutput("cnt_d1", 32'(cnt_d1), 32'(m_cnt1));
        checkOutput("idle", 32'(idle), 32'(m_idle && !any_ne && !s1_v));

        seen_pop0 = pop_vc0;
        seen_pop1 = pop_vc1;
        if (pop_vc0 === 1'b1) grant_log = {grant_log, "0"};
        if (pop_vc1 === 1'b1) grant_log = {grant_log, "1"};
        if (push_d0 === 1'b1) begin
            push_total++;
            push_d0_total++;
            ev_dest.push_back(0);
            ev_data.push_back(int'(data_d0));
            ev_cycle.push_back(cycle);
        end
        if (push_d1 === 1'b1) begin
            push_total++;
            ev_dest.push_back(1);
            ev_data.push_back(int'(data_d1));
            ev_cycle.push_back(cycle);
        end

        if (!reset_L) begin
            s1_v = 1'b0;  s2_v = 1'b0;
            m_data0 = '0; m_data1 = '0;
            m_cnt0 = 0;   m_cnt1 = 0;
            m_streak = 0;
            m_run = 1'b0; m_idle = 1'b1;
        end else begin
            s2_v = s1_v;
            s2_w = s1_w;
            if (s2_v && s2_w[DEST_BIT]) begin
                m_data1 = s2_w;
                m_cnt1  = (m_cnt1 + 1) % CNT_MOD;
            end else if (s2_v) begin
                m_data0 = s2_w;
                m_cnt0  = (m_cnt0 + 1) % CNT_MOD;
            end
            s1_v = exp_pop0 || exp_pop1;
            if (exp_pop0)      s1_w = q0[0];
            else if (exp_pop1) s1_w = q1[0];
            if (exp_pop1 || vc1_empty) m_streak = 0;
            else if (exp_pop0)         m_streak++;
            m_idle = (!any_ne && !pause_any) || (m_idle && !any_ne);
            m_run  = !pause_any && any_ne;
        end
    end

    task automatic sync_empty();
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
    endtask

    task automatic load_word(input int vc, input logic [DATA_SIZE-1:0] w);
        if (vc == 0) q0.push_back(w);
        else         q1.push_back(w);
        sync_empty();
    endtask

    // One clock: FIFO read data follows a pop into the next cycle.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (seen_pop0 && q0.size() > 0) vc0_data = q0.pop_front();
            if (seen_pop1 && q1.size() > 0) vc1_data = q1.pop_front();
            sync_empty();
        end
    endtask

    task automatic applyStimulus(input logic rst_n, input logic p0, input logic p1);
        reset_L  = rst_n;
        pause_d0 = p0;
        pause_d1 = p1;
        #1;
    endtask

    task automatic reset_pulse();
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(2);
        applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout: %0d words left, expected 0",
                     q0.size() + q1.size());
        end
        tick(3);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        logic [DATA_SIZE-1:0] w;

        // Reset held with both VCs loaded: nothing moves.
        for (int i = 0; i < 3; i++) begin
            load_word(0, DATA_SIZE'($urandom));
            load_word(1, DATA_SIZE'($urandom));
        end
        tick(3);
        checkOutput("t1_pop_vc0", 32'(pop_vc0), 32'(0));
        checkOutput("t1_pop_vc1", 32'(pop_vc1), 32'(0));
        checkOutput("t1_push_d0", 32'(push_d0), 32'(0));
        checkOutput("t1_cnt_d1", 32'(cnt_d1), 32'(0));
        checkOutput("t1_idle", 32'(idle), 32'(0));
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t1_idle_state_no_pop", 32'(pop_vc0), 32'(0));
        drain(50);

        // Two words from VC0 to different destinations.
        reset_pulse();
        ev_dest.delete(); ev_data.delete(); ev_cycle.delete();
        load_word(0, 8'h10);
        load_word(0, 8'h05);
        drain(50);
        checkOutput("t2_push_count", 32'(ev_dest.size()), 32'(2));
        if (ev_dest.size() >= 2) begin
            checkOutput("t2_first_dest", 32'(ev_dest[0]), 32'(1));
            checkOutput("t2_first_data", 32'(ev_data[0]), 32'h10);
            checkOutput("t2_second_dest", 32'(ev_dest[1]), 32'(0));
            checkOutput("t2_second_data", 32'(ev_data[1]), 32'h05);
            checkOutput("t2_back_to_back", 32'(ev_cycle[1] - ev_cycle[0]), 32'(1));
        end
        checkOutput("t2_cnt_d0", 32'(cnt_d0), 32'(1));
        checkOutput("t2_cnt_d1", 32'(cnt_d1), 32'(1));

        // Starvation guard: ten words in each VC.
        reset_pulse();
        grant_log = "";
        for (int i = 0; i < 10; i++) begin
            load_word(0, DATA_SIZE'($urandom));
            load_word(1, DATA_SIZE'($urandom));
        end
        drain(100);
        checks++;
        if (grant_log != "00001000010011111111") begin
            errors++;
            $display("[TB] FAIL t3_grant_order: got %s, expected 00001000010011111111", grant_log);
        end

        // Pause in the middle of a stream.
        for (int i = 0; i < 20; i++) load_word(0, DATA_SIZE'($urandom));
        tick(5);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t4_pop_stops", 32'(pop_vc0), 32'(0));
        base = push_total;
        tick(6);
        checkOutput("t4_late_pushes", 32'(push_total - base), 32'(2));
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t4_hold_on_release", 32'(pop_vc0), 32'(0));
        tick(1);
        checkOutput("t4_pop_resumes", 32'(pop_vc0), 32'(1));
        drain(100);

        // 256 words to D0: the counter wraps back to zero.
        reset_pulse();
        base = push_d0_total;
        for (int i = 0; i < 256; i++) begin
            w = DATA_SIZE'($urandom);
            w[DEST_BIT] = 1'b0;
            load_word(i % 2, w);
        end
        drain(600);
        checkOutput("t5_d0_pushes", 32'(push_d0_total - base), 32'(256));
        checkOutput("t5_cnt_d0_wrapped", 32'(cnt_d0), 32'(0));
        checkOutput("t5_cnt_d1", 32'(cnt_d1), 32'(0));

        // Reset pulse while words are in flight.
        for (int i = 0; i < 10; i++) load_word(0, DATA_SIZE'($urandom));
        tick(4);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(1);
        checkOutput("t6_push_d0", 32'(push_d0), 32'(0));
        checkOutput("t6_push_d1", 32'(push_d1), 32'(0));
        checkOutput("t6_data_d0", 32'(data_d0), 32'(0));
        checkOutput("t6_data_d1", 32'(data_d1), 32'(0));
        checkOutput("t6_cnt_d0", 32'(cnt_d0), 32'(0));
        checkOutput("t6_pop_vc0", 32'(pop_vc0), 32'(0));
        applyStimulus(1'b1, 1'b0, 1'b0);
        drain(100);

        // Randomised traffic, pauses and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 8) load_word(0, DATA_SIZE'($urandom));
            if ($urandom_range(0, 2) == 0 && q1.size() < 8) load_word(1, DATA_SIZE'($urandom));
            applyStimulus(($urandom_range(0, 149) != 0),
                          ($urandom_range(0, 7) == 0) ? ~pause_d0 : pause_d0,
                          ($urandom_range(0, 7) == 0) ? ~pause_d1 : pause_d1);
            tick(1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        drain(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
